dff_bank_sched: RTL and testbench
=================================

# dff_bank_sched

Round-robin write scheduler for a shared W-bit D-flip-flop storage register, with a fixed-priority fallback. NREQ requesters compete to write the register; the block arbitrates, loads the winner's data, returns a one-cycle grant, and enforces a configurable cool-down between writes. It sits between the sequential-circuit storage elements and any multi-master logic that updates them.

## Interface
- `NREQ`, 4: number of requesters, ≥2.
- `W`, 8: storage register width.
- `HOLD_CYC`, 1: cool-down cycles after each write, 0..15.
- `IW`, $clog2(NREQ): index width, derived.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous and active-low (one clock; reset synchronous, active-low).
- `req`  in  NREQ  per-requester write request, level.
- `wdata`  in  NREQ*W  requester i data on bits [i*W +: W].
- `gnt`  out  NREQ  one-hot write acknowledge, one-cycle pulse.
- `q`  out  W  shared register contents.
- `qbar`  out  W  bitwise inverse of `q`.
- `owner`  out  IW  index of the last successful writer.
- `valid`  out  1  high once any write has completed since reset.
- `busy`  out  1  high in GRANT and HOLD.

## Operation
- FSM states: IDLE, GRANT, HOLD.
- IDLE: if `req` ≠ 0, pick a winner, store its index in `sel`, and go to GRANT. Otherwise stay in IDLE.
- GRANT:
  - If `req[sel]` = 1: `gnt[sel]` = 1, `q` ← `wdata[sel]`, `owner` ← `sel`, `valid` ← 1, and the RR pointer ← (`sel`+1) mod NREQ.
  - Next state is HOLD, or IDLE when HOLD_CYC = 0.
  - If `req[sel]` = 0 (withdrawal): no `gnt`, no load, pointer unchanged, go to IDLE.
- HOLD: down-counter loaded with HOLD_CYC−1 on entry; return to IDLE when it reaches 0. `req` is ignored.
- Arbitration in round-robin mode: first set `req` bit scanning upward from the pointer, wrapping past NREQ−1 to 0. Pointer resets to 0.
- `gnt` = (state == GRANT) & `req[sel]` & `rst`, decoded one-hot. Never more than one bit set.
- `qbar` = ~`q`, combinational.
- A requester holds `req` and `wdata` stable until it sees its `gnt` bit. Dropping `req` earlier withdraws the request.
- Reset values: state IDLE, `q` = 0, `qbar` = all ones, `gnt` = 0, `owner` = 0, `valid` = 0, `busy` = 0, pointer = 0, counter = 0.

## Timing
- Request seen at edge N (state IDLE) → GRANT during cycle N+1 with `gnt` high → new `q`/`owner`/`valid` visible from cycle N+2.
- Write period under continuous requests: 2+HOLD_CYC cycles.
- `req` changes during GRANT other than `req[sel]`, and all `req` changes during HOLD, have no effect.
- `rst` low at any edge, including mid-GRANT: all registers take reset values at that edge and the pending load is discarded. `gnt` is forced 0 throughout a cycle in which `rst` is low.
- Simultaneous requests are resolved only by the arbitration rule; no two loads ever share a cycle.

## Configuration
- `DFF_BANK_SCHED_RR_EN` defined: round-robin arbitration as above.
- Not defined: fixed priority, lowest set index wins. Pointer logic is removed and `sel` ignores history.
- All other behaviour is identical in both builds.

## Test plan
Tests use NREQ=4, W=8, HOLD_CYC=1.
- Reset: `rst`=0 for 2 cycles with `req`=4'b1111 → `q`=8'h00, `qbar`=8'hFF, `gnt`=0, `valid`=0, `busy`=0 throughout.
- Single write: `req`=4'b0010 and `wdata[15:8]`=8'hA5 at edge N → `gnt`=4'b0010 only in cycle N+1. From N+2: `q`=8'hA5, `qbar`=8'h5A, `owner`=1, `valid`=1. `busy` high in N+1..N+2.
- Fairness: `req`=4'b1111 held, with RR_EN → `gnt` sequence 0001, 0010, 0100, 1000, 0001 at 3-cycle spacing. Without RR_EN → 0001 repeated.
- Withdrawal: `req`=4'b0100 at edge N, dropped to 0 in cycle N+1 → no `gnt`, `q` unchanged, IDLE in N+2. A subsequent `req`=4'b1111 with RR_EN grants index 0 first.
- Reset mid-GRANT: `rst`=0 during the GRANT cycle for `wdata`=8'h3C → `gnt`=0 that cycle, and after the edge `q`=8'h00, `valid`=0, state IDLE.
- HOLD_CYC=0 build: `req`=4'b1000 held → `gnt[3]` every 2 cycles, `busy` high in alternate cycles.

Source files
------------

// File: rtl/dff_bank_sched_if.sv
// Purpose: requester-side bundle for the shared-register write scheduler.
// Ports: req/wdata driven by requesters (master); gnt/q/qbar/owner/valid/busy driven by the scheduler (slave).
// Latency/backpressure: none here; this is wiring only, timing lives in dff_bank_sched.
interface dff_bank_sched_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] wdata;
  logic [NREQ-1:0]   gnt;
  logic [W-1:0]      q;
  logic [W-1:0]      qbar;
  logic [IW-1:0]     owner;
  logic              valid;
  logic              busy;

  modport master (
    output req, wdata,
    input  gnt, q, qbar, owner, valid, busy
  );

  modport slave (
    input  req, wdata,
    output gnt, q, qbar, owner, valid, busy
  );
endinterface

// File: rtl/dff_bank_sched.sv
// Purpose: arbitrates NREQ writers onto one shared W-bit register, one-cycle gnt per write, HOLD_CYC cool-down.
// Latency: req seen at edge N -> gnt during cycle N+1 -> q/owner/valid updated from cycle N+2; period 2+HOLD_CYC.
// Backpressure: requesters hold req/wdata until their gnt bit; dropping req early withdraws the request.
// Ports: clk, rst (sync, active-low), bus (slave modport: req, wdata in; gnt, q, qbar, owner, valid, busy out).
// Build option: DFF_BANK_SCHED_RR_EN selects round-robin arbitration; otherwise lowest index wins.
module dff_bank_sched #(
  parameter int NREQ     = 4,
  parameter int W        = 8,
  parameter int HOLD_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  dff_bank_sched_if.slave  bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Counter reload value; irrelevant when HOLD_CYC is 0 because HOLD is skipped.
  localparam logic [3:0] HOLD_LD = (HOLD_CYC > 0) ? 4'(HOLD_CYC - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   sel;
  logic [3:0]      cnt;
  logic [W-1:0]    q_r;
  logic [IW-1:0]   owner_r;
  logic            valid_r;

  logic [IW-1:0]   win;
  logic            any_req;
  logic            sel_req;
  logic [NREQ-1:0] gnt_c;

  assign any_req = |bus.req;
  assign sel_req = bus.req[sel];

`ifdef DFF_BANK_SCHED_RR_EN
  // Round-robin pointer: index that gets first look on the next arbitration.
  logic [IW-1:0] ptr;
  logic [IW:0]   scan;

  // Scan from ptr upward with wrap. Iterating from the farthest offset down
  // lets the nearest set request overwrite earlier hits, so no found flag.
  always_comb begin
    win  = '0;
    scan = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan = {1'b0, ptr} + (IW+1)'(k);
      if (scan >= (IW+1)'(NREQ))
        scan = scan - (IW+1)'(NREQ);
      if (bus.req[scan[IW-1:0]])
        win = scan[IW-1:0];
    end
  end
`else
  // Fixed priority: lowest set index wins, no history.
  always_comb begin
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[i])
        win = IW'(i);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      sel     <= '0;
      cnt     <= '0;
      q_r     <= '0;
      owner_r <= '0;
      valid_r <= 1'b0;
`ifdef DFF_BANK_SCHED_RR_EN
      ptr     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            sel   <= win;
            state <= GRANT;
          end
        end

        GRANT: begin
          if (sel_req) begin
            q_r     <= bus.wdata[int'(sel)*W +: W];
            owner_r <= sel;
            valid_r <= 1'b1;
`ifdef DFF_BANK_SCHED_RR_EN
            ptr     <= (int'(sel) == NREQ - 1) ? '0 : sel + 1'b1;
`endif
            if (HOLD_CYC == 0) begin
              state <= IDLE;
            end else begin
              cnt   <= HOLD_LD;
              state <= HOLD;
            end
          end else begin
            // Requester withdrew before being acknowledged: nothing is written.
            state <= IDLE;
          end
        end

        HOLD: begin
          if (cnt == 4'd0)
            state <= IDLE;
          else
            cnt <= cnt - 4'd1;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // gnt is combinational so a withdrawal or a reset in the GRANT cycle
  // suppresses the acknowledge in that same cycle.
  always_comb begin
    gnt_c = '0;
    if ((state == GRANT) && sel_req && rst)
      gnt_c[sel] = 1'b1;
  end

  assign bus.gnt   = gnt_c;
  assign bus.q     = q_r;
  assign bus.qbar  = ~q_r;
  assign bus.owner = owner_r;
  assign bus.valid = valid_r;
  assign bus.busy  = (state != IDLE);

endmodule

// File: tb/tb_dff_bank_sched.sv
module tb_dff_bank_sched;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  dff_bank_sched_if #(.NREQ(4), .W(8)) b1 ();
  dff_bank_sched_if #(.NREQ(4), .W(8)) b0 ();

  dff_bank_sched #(.NREQ(4), .W(8), .HOLD_CYC(1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  dff_bank_sched #(.NREQ(4), .W(8), .HOLD_CYC(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    b1.req   = 4'b1111;
    b1.wdata = 32'hDEADBEEF;
    b0.req   = 4'b1111;
    b0.wdata = 32'hDEADBEEF;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++; if (b1.q !== 8'h00) begin bad++; $display("FAIL reset_q cyc%0d: got %h want 00", c, b1.q); end
      total++; if (b1.qbar !== 8'hFF) begin bad++; $display("FAIL reset_qbar cyc%0d: got %h want ff", c, b1.qbar); end
      total++; if (b1.gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt cyc%0d: got %b want 0000", c, b1.gnt); end
      total++; if (b1.valid !== 1'b0) begin bad++; $display("FAIL reset_valid cyc%0d: got %b want 0", c, b1.valid); end
      total++; if (b1.busy !== 1'b0) begin bad++; $display("FAIL reset_busy cyc%0d: got %b want 0", c, b1.busy); end
      total++; if (b0.gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt_h0 cyc%0d: got %b want 0000", c, b0.gnt); end
    end
    @(posedge clk); #1;
    b1.req = 4'b0000;
    b0.req = 4'b0000;
    rst    = 1'b1;
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    b1.req   = 4'b0010;
    b1.wdata = 32'h0000A500;
    @(negedge clk);
    total++; if (b1.gnt !== 4'b0000) begin bad++; $display("FAIL single_gnt_pre: got %b want 0000", b1.gnt); end
    @(negedge clk);
    total++; if (b1.gnt !== 4'b0010) begin bad++; $display("FAIL single_gnt: got %b want 0010", b1.gnt); end
    total++; if (b1.busy !== 1'b1) begin bad++; $display("FAIL single_busy_n1: got %b want 1", b1.busy); end
    total++; if (b1.q !== 8'h00) begin bad++; $display("FAIL single_q_n1: got %h want 00", b1.q); end
    @(posedge clk); #1;
    b1.req = 4'b0000;
    @(negedge clk);
    total++; if (b1.gnt !== 4'b0000) begin bad++; $display("FAIL single_gnt_n2: got %b want 0000", b1.gnt); end
    total++; if (b1.q !== 8'hA5) begin bad++; $display("FAIL single_q: got %h want a5", b1.q); end
    total++; if (b1.qbar !== 8'h5A) begin bad++; $display("FAIL single_qbar: got %h want 5a", b1.qbar); end
    total++; if (b1.owner !== 2'd1) begin bad++; $display("FAIL single_owner: got %0d want 1", b1.owner); end
    total++; if (b1.valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", b1.valid); end
    total++; if (b1.busy !== 1'b1) begin bad++; $display("FAIL single_busy_n2: got %b want 1", b1.busy); end
    @(negedge clk);
    total++; if (b1.busy !== 1'b0) begin bad++; $display("FAIL single_busy_n3: got %b want 0", b1.busy); end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g [5];
    logic [7:0] exp_q;
    int cycles;
`ifdef DFF_BANK_SCHED_RR_EN
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
    pulse_reset();
    b1.req   = 4'b1111;
    b1.wdata = 32'h44332211;
    cycles   = 0;
    for (int g = 0; g < 5; g++) begin
      while (b1.gnt == 4'b0000 && cycles < 10) begin
        @(negedge clk);
        cycles++;
      end
      total++; if (b1.gnt !== exp_g[g]) begin bad++; $display("FAIL fair_gnt%0d: got %b want %b", g, b1.gnt, exp_g[g]); end
      if (g > 0) begin
        total++; if (cycles !== 3) begin bad++; $display("FAIL fair_spacing%0d: got %0d want 3", g, cycles); end
      end
      case (exp_g[g])
        4'b0001: exp_q = 8'h11;
        4'b0010: exp_q = 8'h22;
        4'b0100: exp_q = 8'h33;
        default: exp_q = 8'h44;
      endcase
      @(negedge clk);
      cycles = 1;
      total++; if (b1.q !== exp_q) begin bad++; $display("FAIL fair_q%0d: got %h want %h", g, b1.q, exp_q); end
    end
    @(posedge clk); #1;
    b1.req = 4'b0000;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_withdrawal();
    int cycles;
    pulse_reset();
    // Write from index 3 first so q is nonzero; in RR builds this also wraps the pointer to 0.
    b1.req   = 4'b1000;
    b1.wdata = 32'h77000000;
    cycles   = 0;
    while (b1.gnt == 4'b0000 && cycles < 10) begin
      @(negedge clk);
      cycles++;
    end
    total++; if (b1.gnt !== 4'b1000) begin bad++; $display("FAIL wd_setup_gnt: got %b want 1000", b1.gnt); end
    @(posedge clk); #1;
    b1.req = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    b1.req   = 4'b0100;
    b1.wdata = 32'h00EE0011;
    @(posedge clk); #1;
    b1.req = 4'b0000;
    @(negedge clk);
    total++; if (b1.gnt !== 4'b0000) begin bad++; $display("FAIL wd_gnt: got %b want 0000", b1.gnt); end
    total++; if (b1.busy !== 1'b1) begin bad++; $display("FAIL wd_busy_grant: got %b want 1", b1.busy); end
    @(negedge clk);
    total++; if (b1.busy !== 1'b0) begin bad++; $display("FAIL wd_idle: got busy %b want 0", b1.busy); end
    total++; if (b1.q !== 8'h77) begin bad++; $display("FAIL wd_q: got %h want 77", b1.q); end
    total++; if (b1.owner !== 2'd3) begin bad++; $display("FAIL wd_owner: got %0d want 3", b1.owner); end
    @(posedge clk); #1;
    b1.req = 4'b1111;
    cycles = 0;
    while (b1.gnt == 4'b0000 && cycles < 10) begin
      @(negedge clk);
      cycles++;
    end
    total++; if (b1.gnt !== 4'b0001) begin bad++; $display("FAIL wd_next_gnt: got %b want 0001", b1.gnt); end
    @(posedge clk); #1;
    b1.req = 4'b0000;
    @(negedge clk);
    total++; if (b1.q !== 8'h11) begin bad++; $display("FAIL wd_next_q: got %h want 11", b1.q); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_grant();
    b1.req   = 4'b0001;
    b1.wdata = 32'h0000003C;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if (b1.gnt !== 4'b0000) begin bad++; $display("FAIL rmg_gnt: got %b want 0000", b1.gnt); end
    total++; if (b1.busy !== 1'b1) begin bad++; $display("FAIL rmg_busy_grant: got %b want 1", b1.busy); end
    @(posedge clk); #1;
    rst    = 1'b1;
    b1.req = 4'b0000;
    @(negedge clk);
    total++; if (b1.q !== 8'h00) begin bad++; $display("FAIL rmg_q: got %h want 00", b1.q); end
    total++; if (b1.qbar !== 8'hFF) begin bad++; $display("FAIL rmg_qbar: got %h want ff", b1.qbar); end
    total++; if (b1.valid !== 1'b0) begin bad++; $display("FAIL rmg_valid: got %b want 0", b1.valid); end
    total++; if (b1.busy !== 1'b0) begin bad++; $display("FAIL rmg_busy: got %b want 0", b1.busy); end
    total++; if (b1.owner !== 2'd0) begin bad++; $display("FAIL rmg_owner: got %0d want 0", b1.owner); end
  endtask

  task automatic test_hold0();
    logic [3:0] exp_gnt;
    logic       exp_busy;
    @(posedge clk); #1;
    b0.req   = 4'b1000;
    b0.wdata = 32'h5B000000;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_gnt  = (k % 2 == 0) ? 4'b1000 : 4'b0000;
      exp_busy = (k % 2 == 0);
      total++; if (b0.gnt !== exp_gnt) begin bad++; $display("FAIL h0_gnt%0d: got %b want %b", k, b0.gnt, exp_gnt); end
      total++; if (b0.busy !== exp_busy) begin bad++; $display("FAIL h0_busy%0d: got %b want %b", k, b0.busy, exp_busy); end
      if (k >= 1) begin
        total++; if (b0.q !== 8'h5B) begin bad++; $display("FAIL h0_q%0d: got %h want 5b", k, b0.q); end
      end
    end
    @(posedge clk); #1;
    b0.req = 4'b0000;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b0;
    b1.req   = '0;
    b1.wdata = '0;
    b0.req   = '0;
    b0.wdata = '0;
    test_reset();
    test_single();
    test_fairness();
    test_withdrawal();
    test_reset_mid_grant();
    test_hold0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
